// File: rtl/io_tx_byte_unpacker.sv
// Word-to-byte unpacker on the peripheral clock, fed from the TX FIFO read side.
// Each accepted word streams out as 1, 2 or 4 bytes at up to one byte per cycle, with no bubble between words.
module io_tx_byte_unpacker #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic [1:0]            cfg_size_i,
    input  logic                  cfg_msb_first_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [7:0]            out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  out_last_o,
    output logic                  busy_o
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_idx;
    logic [2:0]            r_nbytes;
    logic                  r_msb;

    logic                  accept;
    logic                  out_hs;
    logic                  last_byte;
    logic [2:0]            size_dec;
    logic [2:0]            sel;

    // Size codes 2 and 3 both mean a full 4-byte word.
    always_comb begin
        size_dec = 3'd4;
        case (cfg_size_i)
            2'd0:    size_dec = 3'd1;
            2'd1:    size_dec = 3'd2;
            default: size_dec = 3'd4;
        endcase
    end

    assign last_byte = (state_q == SHIFT) && ({1'b0, r_idx} == (r_nbytes - 3'd1));
    assign out_hs    = (state_q == SHIFT) && out_ready_i;

    // The last-byte handshake opens the input in the same cycle, so words chain back-to-back.
    assign in_ready_o = ~rst_i & ~clr_i &
                        ((state_q == IDLE) | ((state_q == SHIFT) & last_byte & out_ready_i));
    assign accept     = in_valid_i & in_ready_o;

    assign sel = r_msb ? (r_nbytes - 3'd1 - {1'b0, r_idx}) : {1'b0, r_idx};

    always_comb begin
        out_data_o = 8'h00;
        if (state_q == SHIFT) begin
            case (sel[1:0])
                2'd0:    out_data_o = r_data[7:0];
                2'd1:    out_data_o = r_data[15:8];
                2'd2:    out_data_o = r_data[23:16];
                default: out_data_o = r_data[31:24];
            endcase
        end
    end

    assign out_valid_o = (state_q == SHIFT);
    assign out_last_o  = last_byte;
    assign busy_o      = (state_q == SHIFT);

    always_comb begin
        state_d = state_q;
        if (clr_i) begin
            state_d = IDLE;
        end else if (accept) begin
            state_d = SHIFT;
        end else if (out_hs && last_byte) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            r_data   <= '0;
            r_idx    <= 2'd0;
            r_nbytes <= 3'd0;
            r_msb    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (clr_i) begin
                r_idx <= 2'd0;
            end else if (accept) begin
                r_data   <= in_data_i;
                r_nbytes <= size_dec;
                r_msb    <= cfg_msb_first_i;
                r_idx    <= 2'd0;
            end else if (out_hs && !last_byte) begin
                r_idx <= r_idx + 2'd1;
            end
        end
    end

    // Only the 32-bit layout (four byte lanes) is supported by the byte mux.
    if (NUM_BYTES != 4) begin : g_bad_width
        $error("io_tx_byte_unpacker: DATA_WIDTH must be 32");
    end

endmodule

// File: tb/tb_io_tx_byte_unpacker.sv
// Scoreboard bench for io_tx_byte_unpacker: the driver issues words, a negedge monitor
// checks each presented byte against a byte queue built from the size/order rules.
module tb_io_tx_byte_unpacker;

    logic        clk = 1'b0;
    logic        rst, clr;
    logic [1:0]  cfg_size;
    logic        cfg_msb;
    logic [31:0] in_data;
    logic        in_valid, in_ready;
    logic [7:0]  out_data;
    logic        out_valid, out_ready, out_last, busy;

    always #5 clk = ~clk;

    io_tx_byte_unpacker #(.DATA_WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst), .clr_i(clr),
        .cfg_size_i(cfg_size), .cfg_msb_first_i(cfg_msb),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_last_o(out_last), .busy_o(busy)
    );

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   started = 0;
    bit   rand_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the byte stream a word should produce, in emission order.
    task automatic push_word(input logic [31:0] w, input logic [1:0] sz, input logic msb);
        int   n;
        int   b;
        exp_t e;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        for (int i = 0; i < n; i++) begin
            b = msb ? (n - 1 - i) : i;
            e.data = 8'((w >> (8 * b)) & 32'hFF);
            e.last = (i == n - 1);
            q.push_back(e);
        end
    endtask

    always @(posedge clk) started <= 1'b1;

    always @(negedge clk) begin
        if (started) begin
            logic exp_rdy;
            exp_rdy = !rst && !clr && (q.size() == 0 || (q.size() == 1 && out_ready));
            check("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
            check("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
            check("busy", {31'b0, busy}, {31'b0, q.size() != 0});
            if (q.size() != 0) begin
                check("out_data", {24'b0, out_data}, {24'b0, q[0].data});
                check("out_last", {31'b0, out_last}, {31'b0, q[0].last});
            end
            if (rst || clr) begin
                q.delete();
            end else begin
                if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
                if (in_valid && in_ready) push_word(in_data, cfg_size, cfg_msb);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w, input logic [1:0] sz, input logic msb);
        bit ok;
        ok = 0;
        in_data  = w;
        cfg_size = sz;
        cfg_msb  = msb;
        in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            bad++;
            total++;
            $display("FAIL send_timeout: word %0h never accepted", w);
        end
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; cfg_size = 2'd0; cfg_msb = 1'b0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        tick(); tick();
        @(negedge clk);
        check("rst_out_data", {24'b0, out_data}, 32'h0);
        check("rst_out_last", {31'b0, out_last}, 32'h0);
        check("rst_in_ready", {31'b0, in_ready}, 32'h0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;

        send(32'h44332211, 2'd2, 1'b0);
        repeat (6) tick();

        send(32'h000000AA, 2'd0, 1'b0);
        send(32'h000000BB, 2'd0, 1'b0);
        repeat (3) tick();

        send(32'hDDCCBBAA, 2'd2, 1'b0);
        tick();
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
        repeat (5) tick();

        send(32'h1234BEEF, 2'd1, 1'b1);
        repeat (4) tick();

        send(32'h04030201, 2'd2, 1'b0);
        tick();
        clr = 1'b1;
        out_ready = 1'b0;
        tick();
        clr = 1'b0;
        out_ready = 1'b1;
        repeat (2) tick();
        send(32'h08070605, 2'd2, 1'b0);
        repeat (5) tick();

        send(32'hA1B2C3D4, 2'd2, 1'b1);
        cfg_size = 2'd0;
        cfg_msb  = 1'b0;
        repeat (6) tick();
        send(32'h55667788, 2'd0, 1'b0);
        repeat (3) tick();
        send(32'h99887766, 2'd3, 1'b0);
        tick();
        rst = 1'b1;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("after_rst_valid", {31'b0, out_valid}, 32'h0);
        check("after_rst_busy", {31'b0, busy}, 32'h0);
        tick();
        out_ready = 1'b1;

        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    send($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
                    cfg_size = 2'($urandom_range(0, 3));
                    cfg_msb  = 1'($urandom_range(0, 1));
                    repeat ($urandom_range(0, 2)) tick();
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    tick();
                    clr = ($urandom_range(0, 39) == 0);
                    out_ready = clr ? 1'b0 : ($urandom_range(0, 3) != 0);
                end
                clr = 1'b0;
                out_ready = 1'b1;
            end
        join

        for (int k = 0; k < 20 && q.size() != 0; k++) tick();
        check("drain_empty", q.size(), 32'h0);
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
